// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single shared block memory port.
// Requester 0 is instruction fetch, requester 1 is the loader/data path.
// One transaction is outstanding at a time: IDLE -> ACCESS (MEM_LAT cycles)
// -> RESP (one-cycle completion pulse) -> IDLE.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : round-robin on ties (grant the requester that
//                              was not granted last; requester 0 wins the
//                              first tie after reset).
//                  undefined : fixed priority, requester 0 always wins ties.
//
// Parameters: ADDR_W (block address width), BLOCK_W (block width),
//             MEM_LAT (memory access cycles, 1..15).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake for requester N
//   reqN_addr/we/wdata          request payload for requester N
//   rspN_valid                  one-cycle completion pulse for requester N
//   rsp_data                    last read block (shared)
//   mem_addr/rd/wr/wdata        shared memory port, mem_rdata read return
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int BLOCK_W = 1024,
    parameter int MEM_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic               req0_we,
    input  logic [BLOCK_W-1:0] req0_wdata,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic               req1_we,
    input  logic [BLOCK_W-1:0] req1_wdata,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [BLOCK_W-1:0] rsp_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value loaded on acceptance; ACCESS lasts LAT_LOAD+1 cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic                 owner_r;
    logic                 we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [BLOCK_W-1:0]   mem_wdata_r;
    logic                 mem_rd_r;
    logic                 mem_wr_r;
    logic [BLOCK_W-1:0]   rsp_data_r;
    logic                 rsp0_valid_r;
    logic                 rsp1_valid_r;
    logic                 busy_r;

    logic                 grant_valid_s;
    logic                 grant_idx_s;
    logic                 accept_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic                 sel_we_s;
    logic [BLOCK_W-1:0]   sel_wdata_s;

`ifdef MEM_ARB_RR_EN
    logic                 last_r;

    // Round-robin pointer: remembers the requester granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (accept_s) begin
            last_r <= grant_idx_s;
        end
    end
`endif

    // Arbitration: pick the winner among the valid requesters.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
`ifdef MEM_ARB_RR_EN
            grant_idx_s   = ~last_r;
`else
            grant_idx_s   = 1'b0;
`endif
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = 1'b0;
        end
    end

    // Ready must follow valid within the cycle, so it is decoded from the
    // state register; rst_n gating keeps it low while reset is asserted.
    assign accept_s    = rst_n && (state_r == IDLE) && grant_valid_s;
    assign req0_ready  = accept_s && !grant_idx_s;
    assign req1_ready  = accept_s && grant_idx_s;

    assign sel_addr_s  = grant_idx_s ? req1_addr  : req0_addr;
    assign sel_we_s    = grant_idx_s ? req1_we    : req0_we;
    assign sel_wdata_s = grant_idx_s ? req1_wdata : req0_wdata;

    // Transaction FSM with registered memory-port and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            rsp_data_r   <= '0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r     <= grant_idx_s;
                        we_r        <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        mem_rd_r    <= ~sel_we_s;
                        mem_wr_r    <= sel_we_s;
                        cnt_r       <= LAT_LOAD;
                        busy_r      <= 1'b1;
                        state_r     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        // Last access cycle: read data is valid on mem_rdata now.
                        if (!we_r) begin
                            rsp_data_r <= mem_rdata;
                        end
                        mem_rd_r     <= 1'b0;
                        mem_wr_r     <= 1'b0;
                        rsp0_valid_r <= ~owner_r;
                        rsp1_valid_r <= owner_r;
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    cnt_r        <= 4'd0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_rd     = mem_rd_r;
    assign mem_wr     = mem_wr_r;
    assign rsp_data   = rsp_data_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives two mem_arbiter instances (MEM_LAT=4 and MEM_LAT=1) with the same
// request stimulus. A cycle-timeline model (acceptance cycle + latency) gives
// the expected value of every output each cycle; directed checks with
// hand-computed constants pin latency, pulse counts, grant order and reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int BW = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [BW-1:0] wd0 = '0, wd1 = '0, mrd = '0;

    logic rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], mrd_o [2], mwr_o [2], bsy [2];
    logic [BW-1:0] rdat [2], mwd [2];
    logic [AW-1:0] madr [2];

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT((g == 0) ? 4 : 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(v0), .req0_ready(rdy0[g]), .req0_addr(a0), .req0_we(we0), .req0_wdata(wd0),
            .req1_valid(v1), .req1_ready(rdy1[g]), .req1_addr(a1), .req1_we(we1), .req1_wdata(wd1),
            .rsp0_valid(rv0[g]), .rsp1_valid(rv1[g]), .rsp_data(rdat[g]),
            .mem_addr(madr[g]), .mem_rd(mrd_o[g]), .mem_wr(mwr_o[g]), .mem_wdata(mwd[g]),
            .mem_rdata(mrd), .busy(bsy[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (low 64 bits) t=%0t", nm, act[63:0], exp[63:0], $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            cyc = 0;
    int            a_m [2];
    bit            infl_m [2], we_m [2], own_m [2], last_m [2];
    logic [AW-1:0] adr_m [2];
    logic [BW-1:0] wdm [2], rdm [2];

    function automatic int lat_of(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic bit model_idle(int d);
        return !infl_m[d] || (cyc >= a_m[d] + lat_of(d) + 1);
    endfunction

    function automatic int winner(int d);
        if (v0 && v1) begin
`ifdef MEM_ARB_RR_EN
            return last_m[d] ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            infl_m[d] = 1'b0; last_m[d] = 1'b1; a_m[d] = 0; we_m[d] = 1'b0; own_m[d] = 1'b0;
            adr_m[d] = '0; wdm[d] = '0; rdm[d] = '0;
        end
    endfunction

    initial model_clear();
    initial forever begin
        @(negedge rst_n);
        model_clear();
    end

    // Model advance on each rising edge: read capture, then acceptance.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int d = 0; d < 2; d++) begin
                int w;
                if (infl_m[d] && (cyc == a_m[d] + lat_of(d) - 1) && !we_m[d]) rdm[d] = mrd;
                if (model_idle(d)) begin
                    w = winner(d);
                    if (w >= 0) begin
                        infl_m[d] = 1'b1; a_m[d] = cyc + 1; own_m[d] = (w == 1);
                        we_m[d]  = (w == 1) ? we1 : we0;
                        adr_m[d] = (w == 1) ? a1 : a0;
                        wdm[d]   = (w == 1) ? wd1 : wd0;
                        last_m[d] = (w == 1);
                    end
                end
            end
        end
        cyc++;
    end

    // Per-cycle compare of every output of both instances.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w, l;
            bit idl, acc, rsp;
            l = lat_of(d); idl = model_idle(d); w = winner(d);
            acc = infl_m[d] && (cyc < a_m[d] + l);
            rsp = infl_m[d] && (cyc == a_m[d] + l);
            chk($sformatf("d%0d.req0_ready", d), rdy0[d], rst_n && idl && (w == 0));
            chk($sformatf("d%0d.req1_ready", d), rdy1[d], rst_n && idl && (w == 1));
            chk($sformatf("d%0d.busy", d), bsy[d], acc || rsp);
            chk($sformatf("d%0d.mem_rd", d), mrd_o[d], acc && !we_m[d]);
            chk($sformatf("d%0d.mem_wr", d), mwr_o[d], acc && we_m[d]);
            chk($sformatf("d%0d.rsp0_valid", d), rv0[d], rsp && !own_m[d]);
            chk($sformatf("d%0d.rsp1_valid", d), rv1[d], rsp && own_m[d]);
            chk($sformatf("d%0d.mem_addr", d), madr[d], adr_m[d]);
            chk($sformatf("d%0d.mem_wdata", d), mwd[d], wdm[d]);
            chk($sformatf("d%0d.rsp_data", d), rdat[d], rdm[d]);
        end
    end

    // ---------------- directed stimulus ----------------
    int r_lat [2], r_rd [2], r_wr [2], r_own [2], r_oth [2];

    task automatic run_txn(input bit idx, input bit we, input logic [AW-1:0] adr,
                           input logic [BW-1:0] wd, input int rst_at, input bit glitch, input bit chg);
        bit found;
        for (int d = 0; d < 2; d++) begin
            r_lat[d] = -1; r_rd[d] = 0; r_wr[d] = 0; r_own[d] = 0; r_oth[d] = 0;
        end
        @(posedge clk); #1;
        if (idx) begin v1 = 1'b1; a1 = adr; we1 = we; wd1 = wd; end
        else     begin v0 = 1'b1; a0 = adr; we0 = we; wd0 = wd; end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (idx ? rdy1[0] : rdy0[0]) begin found = 1'b1; break; end
        end
        chk("accept_within_bound", found, 1'b1);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        if (chg) begin a0 = 8'hEE; a1 = 8'hEE; wd0 = '1; wd1 = '1; we0 = 1'b1; we1 = 1'b1; end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mrd_o[d]) r_rd[d]++;
                if (mwr_o[d]) r_wr[d]++;
                if (idx ? rv1[d] : rv0[d]) begin r_own[d]++; if (r_lat[d] < 0) r_lat[d] = k; end
                if (idx ? rv0[d] : rv1[d]) r_oth[d]++;
            end
            if (glitch && k == 1) begin #1; if (idx) v0 = 1'b1; else v1 = 1'b1; end
            if (glitch && k == 2) begin #1; v0 = 1'b0; v1 = 1'b0; end
            if (rst_at == k) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", bsy[0], 1'b0);
                chk("rst_mem_rd", mrd_o[0], 1'b0);
                chk("rst_mem_addr", madr[0], '0);
                chk("rst_rsp_data", rdat[0], '0);
                chk("rst_mem_wdata", mwd[0], '0);
                @(posedge clk); #3 rst_n = 1'b1;
            end
        end
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; we0 = 1'b0; we1 = 1'b0;
    endtask

    logic [BW-1:0] pat_a, pat_b;
    int g_idx [4], g_cyc [4];
    int ng, n;

    initial begin
        pat_a = {16{64'hA5A5_0123_4567_89AB}};
        pat_b = {16{64'h5A5A_FEDC_BA98_7654}};
        // Reset state, ready held low even with a valid request present.
        #1 v0 = 1'b1;
        #2;
        chk("reset_ready0", rdy0[0], 1'b0);
        chk("reset_busy", bsy[0], 1'b0);
        chk("reset_rsp_data", rdat[0], '0);
        chk("reset_mem_addr", madr[0], '0);
        v0 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Read from requester 0.
        mrd = pat_a;
        run_txn(1'b0, 1'b0, 8'h02, '0, 0, 1'b0, 1'b0);
        chk("rd_latency", 32'(r_lat[0]), 32'd5);
        chk("rd_mem_rd_cycles", 32'(r_rd[0]), 32'd4);
        chk("rd_rsp0_pulses", 32'(r_own[0]), 32'd1);
        chk("rd_rsp1_pulses", 32'(r_oth[0]), 32'd0);
        chk("rd_rsp_data", rdat[0], pat_a);
        chk("rd_mem_addr", madr[0], 8'h02);
        chk("lat1_latency", 32'(r_lat[1]), 32'd2);
        chk("lat1_mem_rd_cycles", 32'(r_rd[1]), 32'd1);

        // Write from requester 1, with a short-lived req0 valid during ACCESS.
        mrd = ~pat_a;
        run_txn(1'b1, 1'b1, 8'h10, 1024'b11110, 0, 1'b1, 1'b0);
        chk("wr_latency", 32'(r_lat[0]), 32'd5);
        chk("wr_mem_wr_cycles", 32'(r_wr[0]), 32'd4);
        chk("wr_mem_rd_cycles", 32'(r_rd[0]), 32'd0);
        chk("wr_rsp1_pulses", 32'(r_own[0]), 32'd1);
        chk("wr_glitch_rsp0", 32'(r_oth[0]), 32'd0);
        chk("wr_rsp_data_kept", rdat[0], pat_a);
        chk("wr_mem_wdata", mwd[0], 1024'd30);

        // Both requesters valid continuously: grant order and spacing.
        mrd = pat_b;
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1; a0 = 8'h20; a1 = 8'h21;
        ng = 0; n = 0;
        while (ng < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (rdy0[0] && v0) begin g_idx[ng] = 0; g_cyc[ng] = n; ng++; end
            else if (rdy1[0] && v1) begin g_idx[ng] = 1; g_cyc[ng] = n; ng++; end
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0;
        chk("arb_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("arb_grant%0d", i), 32'(g_idx[i]), 32'(i % 2));
`else
            chk($sformatf("arb_grant%0d", i), 32'(g_idx[i]), 32'd0);
`endif
            if (i > 0) chk($sformatf("arb_spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd6);
        end
        repeat (10) @(negedge clk);

        // Reset during the third ACCESS cycle aborts silently.
        mrd = pat_a;
        run_txn(1'b0, 1'b0, 8'h44, '0, 3, 1'b0, 1'b0);
        chk("abort_rsp0_pulses", 32'(r_own[0]), 32'd0);
        chk("abort_rsp1_pulses", 32'(r_oth[0]), 32'd0);
        mrd = pat_b;
        run_txn(1'b0, 1'b0, 8'h05, '0, 0, 1'b0, 1'b0);
        chk("post_rst_latency", 32'(r_lat[0]), 32'd5);
        chk("post_rst_rsp_data", rdat[0], pat_b);

        // Request inputs change right after acceptance.
        run_txn(1'b0, 1'b0, 8'h33, '0, 0, 1'b0, 1'b1);
        chk("chg_latency", 32'(r_lat[0]), 32'd5);
        chk("chg_mem_rd_cycles", 32'(r_rd[0]), 32'd4);
        chk("chg_mem_addr", madr[0], 8'h33);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, default 8, address width; BLOCK_W, default 1024, memory block width; MEM_LAT, default 4, memory access cycles (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  request from requester N (N=0: instruction fetch, N=1: loader/data).
REQ-005 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 reqN_addr  input  ADDR_W  block address; reqN_we  input  1  1=write, 0=read; reqN_wdata  input  BLOCK_W  write block.
REQ-007 rspN_valid  output  1  one-cycle completion pulse for requester N.
REQ-008 rsp_data  output  BLOCK_W  read block returned; shared by both requesters.
REQ-009 mem_addr  output  ADDR_W; mem_rd  output  1; mem_wr  output  1; mem_wdata  output  BLOCK_W: shared memory port.
REQ-010 mem_rdata  input  BLOCK_W  memory read block, valid on last access cycle.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, RESP; one transaction outstanding at a time.
REQ-013 In IDLE, at most one reqN_ready SHALL be high: for the arbitration winner among valid requesters; both low if neither valid.
REQ-014 Acceptance SHALL occur on a rising edge with reqN_valid && reqN_ready; addr, we, wdata and requester index are registered; state -> ACCESS, counter loaded with MEM_LAT-1.
REQ-015 In ACCESS, mem_addr/mem_wdata SHALL hold registered values, mem_rd = ~we, mem_wr = we, for exactly MEM_LAT cycles; counter decrements each cycle.
REQ-016 On the edge ending the last ACCESS cycle (counter==0): read transactions capture mem_rdata into rsp_data; state -> RESP.
REQ-017 Write transactions SHALL leave rsp_data unchanged.
REQ-018 In RESP, rspN_valid SHALL be high for exactly one cycle for the owning requester only; state -> IDLE next edge.
REQ-019 Latency: acceptance edge to rspN_valid high = MEM_LAT+1 cycles; back-to-back throughput = one transaction per MEM_LAT+2 cycles.
REQ-020 Outside ACCESS, mem_rd and mem_wr SHALL be 0; mem_addr/mem_wdata hold last values.
REQ-021 Both reqN_ready SHALL be 0 in ACCESS and RESP; requests arriving then wait.
REQ-022 A requester dropping reqN_valid before acceptance SHALL have no effect.
REQ-023 Request inputs changing after acceptance SHALL not affect the transaction in flight.
REQ-024 MEM_LAT=1 SHALL give ACCESS of one cycle; no other boundary changes.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, and all outputs 0 (reqN_ready, rspN_valid, rsp_data, mem_*, busy).
REQ-026 Reset mid-ACCESS or mid-RESP SHALL abort the transaction silently: no rspN_valid pulse after release.
REQ-027 The round-robin pointer SHALL reset to "last granted = 1", so requester 0 wins the first tie.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: round-robin; on tie, grant the requester not granted last; pointer updates on every acceptance.
REQ-029 MEM_ARB_RR_EN undefined: fixed priority; requester 0 always wins ties; no pointer register.

Verification
REQ-030 MEM_LAT=4, req0 read addr 8'h02, mem_rdata=pattern A -> mem_rd high exactly 4 cycles with mem_addr=02; rsp0_valid single pulse 5 cycles after acceptance; rsp_data=A; rsp1_valid never high.
REQ-031 req1 write addr 8'h10, wdata 1024'b11110 -> mem_wr high 4 cycles, mem_wdata=1024'b11110; rsp1_valid pulse; rsp_data unchanged.
REQ-032 Both valid continuously, 4 transactions, MEM_LAT_EN defined as RR (MEM_ARB_RR_EN) -> grant order 0,1,0,1; without macro -> 0,0,0,0; each acceptance MEM_LAT+2=6 cycles apart.
REQ-033 rst_n low for 1 cycle during third ACCESS cycle -> all outputs 0 immediately; no rsp pulse; next request completes normally with 5-cycle latency.
REQ-034 MEM_LAT=1, req0 read -> mem_rd high 1 cycle, rsp0_valid 2 cycles after acceptance.
REQ-035 req0 changes addr during ACCESS -> mem_addr stays at accepted value through completion.
